instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//   Instruction fetch front-end sitting directly upstream of decode/control. Owns the fetch PC and
//   issues word requests to instruction memory over a valid/ready request channel. Buffers in-order
//   responses in a DEPTH-entry FIFO and presents {instr, instr_pc} to decode with a valid/ready handshake.
//   A redirect (taken branch) flushes the FIFO and discards any responses already in flight.
// PARAMETERS
//   DEPTH    4   FIFO entries; also the max outstanding requests (power of 2, >=2)
//   RESET_PC 0   fetch PC loaded on reset (word aligned)
// PORTS
//   clk             in   1   clock, all state on rising edge
//   rst             in   1   synchronous reset, active-high
//   redirect_valid  in   1   branch taken; load redirect_pc, flush
//   redirect_pc     in   32  new fetch address; bits [1:0] ignored (forced 0)
//   mem_req_valid   out  1   request to instruction memory
//   mem_req_addr    out  32  word address of request (PC, [1:0]=0)
//   mem_req_ready   in   1   memory accepts request this cycle
//   mem_rsp_valid   in   1   response word valid (in order, >=1 cycle after accept)
//   mem_rsp_data    in   32  instruction word
//   instr_valid     out  1   head of FIFO valid to decode
//   instr           out  32  head instruction word
//   instr_pc        out  32  PC of head instruction
//   instr_ready     in   1   decode consumes head this cycle
// BEHAVIOUR
//   Reset (rst=1 at edge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=RUN.
//     Outputs: mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, mem_req_addr=RESET_PC.
//     rst overrides redirect and in-flight traffic. Responses arriving after reset are not tracked;
//     memory must be reset with this block.
//   All outputs are driven from registers/FIFO state only; no combinational path from any input.
//   Credits: mem_req_valid = (state==RUN) && (fifo_count + outstanding < DEPTH).
//     Accept = mem_req_valid && mem_req_ready.
//     On accept: fetch_pc += 4 (mod 2^32, 0xFFFFFFFC wraps to 0), outstanding++.
//     Each request's PC is pushed into a DEPTH-entry tag queue.
//   Response (mem_rsp_valid): outstanding--, tag popped.
//     If discard>0: discard--, data dropped.
//     Else: {data, tag} pushed into FIFO; never overflows, guaranteed by credits.
//   Pop = instr_valid && instr_ready; head advances next cycle. Push and pop in the same cycle leave
//     count unchanged. A response into an empty FIFO is visible on instr_valid the next cycle (1-cycle latency).
//   States:
//     RUN:   normal issue.
//     FLUSH: no new requests; waits for discard to reach 0.
//   Redirect (redirect_valid=1, rst=0), highest priority after reset:
//     - fetch_pc <= {redirect_pc[31:2],2'b00}; FIFO cleared. A pop in the same cycle is considered
//       taken by decode, but its entry is flushed anyway.
//     - discard <= outstanding_next: counts a request accepted this cycle, excludes a response
//       consumed this cycle. That same-cycle response is itself dropped.
//     - If discard_next==0 the block stays in RUN; otherwise it goes to FLUSH.
//   FLUSH -> RUN in the cycle discard transitions to 0. Issue resumes from the new fetch_pc on the
//     following cycle. A redirect during FLUSH reloads fetch_pc and recomputes discard; the block stays in FLUSH.
//   Request hold: once mem_req_valid=1, valid and addr are held until accept. The only exception is a
//     redirect, which may withdraw an unaccepted request (valid drops next cycle).
//   Counters (outstanding, discard, fifo_count) are clog2(DEPTH)+1 bits. mem_rsp_valid with
//     outstanding==0 is a protocol error; the bench asserts it never occurs.
// TESTING
//   1. Reset: rst=1 for 2 cycles -> next cycle mem_req_valid=1, mem_req_addr=0x0, instr_valid=0.
//   2. Streaming: memory ready=1, 1-cycle response latency, instr_ready=1 -> instr_pc sequence
//      0x0,0x4,0x8,...; one instruction per cycle after a 3-cycle fill.
//   3. Backpressure: instr_ready=0 -> exactly 4 requests accepted (addr 0x0..0xC), then mem_req_valid=0.
//      Raise instr_ready -> PCs 0x0..0xC delivered in order, then the 5th request is issued at 0x10.
//   4. Redirect in flight: 3-cycle memory latency, 2 outstanding, redirect to 0x103 -> the 2 stale
//      responses are dropped, FLUSH for 2 cycles, then next request at 0x100; first delivered instr_pc=0x100.
//   5. Same-cycle redirect + response + accept -> discard=outstanding_next, the response is dropped,
//      and no stale PC is ever delivered.
//   6. Wrap: redirect to 0xFFFFFFF8 -> requests issued at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.

Source files
------------

// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: fetch front-end bundle; redirect in, memory request/response, decode valid/ready (master = fetch block, slave = its environment)
interface instr_prefetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
  );
  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: credit-limited fetch PC issuer with in-order response FIFO and redirect flush; ports clk, rst, bus (instr_prefetch_queue_if.master)
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                    clk,
  input logic                    rst,
  instr_prefetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t        r_state, w_state_n;
  logic [31:0]   r_pc, w_pc_n;
  logic [CW-1:0] r_out, r_disc, r_cnt, w_out_n, w_disc_n, w_cnt_n;
  logic [CW:0]   w_sum;
  logic [AW-1:0] r_wp, r_rp, r_tw, r_tr;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_ipc [DEPTH];
  logic [31:0]   r_tag [DEPTH];
  logic          r_req_v, w_req_v_n, w_acc, w_pop, w_push, w_valid;
  always_comb begin
    w_valid   = r_cnt != '0;
    w_acc     = r_req_v & bus.mem_req_ready;
    w_pop     = w_valid & bus.instr_ready;
    w_push    = bus.mem_rsp_valid & ~bus.redirect_valid & (r_disc == '0);
    w_out_n   = r_out + CW'(w_acc) - CW'(bus.mem_rsp_valid);
    w_disc_n  = bus.redirect_valid ? w_out_n :
                (bus.mem_rsp_valid && r_disc != '0) ? r_disc - CW'(1) : r_disc;
    w_cnt_n   = bus.redirect_valid ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
    w_state_n = bus.redirect_valid ? (w_disc_n != '0 ? FLUSH : RUN) :
                (w_disc_n == '0 ? RUN : r_state);
    w_pc_n    = bus.redirect_valid ? (bus.redirect_pc & ~32'h3) : w_acc ? r_pc + 32'd4 : r_pc;
    w_sum     = {1'b0, w_cnt_n} + {1'b0, w_out_n};
    w_req_v_n = (w_state_n == RUN) && (w_sum < (CW+1)'(DEPTH));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_disc  <= '0;
      r_cnt   <= '0;
      r_req_v <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_tw    <= '0;
      r_tr    <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_out   <= w_out_n;
      r_disc  <= w_disc_n;
      r_cnt   <= w_cnt_n;
      r_req_v <= w_req_v_n;
      if (w_acc) begin
        r_tag[r_tw] <= r_pc;
        r_tw        <= r_tw + AW'(1);
      end
      if (bus.mem_rsp_valid) r_tr <= r_tr + AW'(1);
      if (w_push) begin
        r_data[r_wp] <= bus.mem_rsp_data;
        r_ipc[r_wp]  <= r_tag[r_tr];
      end
      r_wp <= bus.redirect_valid ? '0 : r_wp + AW'(w_push);
      r_rp <= bus.redirect_valid ? '0 : r_rp + AW'(w_pop);
    end
  end
  assign bus.mem_req_valid = r_req_v;
  assign bus.mem_req_addr  = r_pc;
  assign bus.instr_valid   = w_valid;
  assign bus.instr         = w_valid ? r_data[r_rp] : '0;
  assign bus.instr_pc      = w_valid ? r_ipc[r_rp] : '0;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: randomized phases against a queue-based fetch/memory reference model
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          due;
  } req_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  instr_prefetch_queue_if bus();
  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  req_t        inflight[$];
  logic [31:0] fifo[$];
  logic [31:0] m_pc;
  bit          m_rst;
  int          cyc, n_chk, n_err, lat_min, lat_max;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1234_5678;
  endfunction
  function automatic bit exp_req();
    bit stale = 1'b0;
    foreach (inflight[i]) stale |= inflight[i].stale;
    return !m_rst && !stale && (fifo.size() + inflight.size() < DEPTH);
  endfunction
  task automatic model_update();
    bit   acc, pop;
    req_t e;
    if (rst) begin
      inflight.delete();
      fifo.delete();
      m_pc  = 32'h0;
      m_rst = 1'b1;
    end else begin
      acc = exp_req() && bus.mem_req_ready;
      pop = fifo.size() > 0 && bus.instr_ready;
      if (pop) void'(fifo.pop_front());
      if (bus.mem_rsp_valid) begin
        chk("rsp_outstanding", 32'(inflight.size() > 0), 32'h1);
        if (inflight.size() > 0) begin
          e = inflight.pop_front();
          if (!e.stale && !bus.redirect_valid) fifo.push_back(e.pc);
        end
      end
      if (acc) begin
        e.pc    = m_pc;
        e.stale = 1'b0;
        e.due   = cyc + int'($urandom_range(lat_min, lat_max));
        inflight.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      if (bus.redirect_valid) begin
        fifo.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc = bus.redirect_pc & ~32'h3;
      end
      m_rst = 1'b0;
    end
    cyc++;
  endtask
  task automatic check_outputs();
    chk("req_valid", 32'(bus.mem_req_valid), 32'(exp_req()));
    chk("req_addr", bus.mem_req_addr, m_pc);
    chk("instr_valid", 32'(bus.instr_valid), 32'(fifo.size() > 0));
    if (fifo.size() > 0) begin
      chk("instr_pc", bus.instr_pc, fifo[0]);
      chk("instr", bus.instr, data_of(fifo[0]));
    end else if (m_rst) begin
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_instr_pc", bus.instr_pc, 32'h0);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask
  task automatic drive(input int mr, input int ir, input int rd, input logic [31:0] base,
                       input bit spread, input bit force_rd, input int prst);
    logic [31:0] off;
    off = spread ? 32'($urandom_range(0, 63)) << 2 : 32'h0;
    rst                = $urandom_range(0, 999) < prst;
    bus.mem_req_ready  = $urandom_range(0, 99) < mr;
    bus.instr_ready    = $urandom_range(0, 99) < ir;
    bus.redirect_valid = force_rd || ($urandom_range(0, 99) < rd);
    bus.redirect_pc    = (base + off) | 32'($urandom_range(0, 3));
    bus.mem_rsp_valid  = inflight.size() > 0 && inflight[0].due <= cyc;
    bus.mem_rsp_data   = bus.mem_rsp_valid ? data_of(inflight[0].pc) : $urandom;
  endtask
  task automatic phase(input int n, input int mr, input int lmin, input int lmax, input int ir,
                       input int rd, input logic [31:0] base, input bit spread, input bit force_first,
                       input int prst);
    lat_min = lmin;
    lat_max = lmax;
    for (int i = 0; i < n; i++) begin
      drive(mr, ir, rd, base, spread, force_first && i == 0, prst);
      step();
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    bus.instr_ready    = 1'b0;
    lat_min = 1;
    lat_max = 1;
    step();
    step();
    phase(40, 100, 1, 1, 100, 0, 32'h0, 0, 0, 0);
    phase(20, 100, 1, 1, 0, 0, 32'h0, 0, 0, 0);
    phase(20, 100, 1, 1, 100, 0, 32'h0, 0, 0, 0);
    phase(4, 100, 3, 3, 100, 0, 32'h0, 0, 0, 0);
    phase(30, 100, 3, 3, 100, 0, 32'h100, 0, 1, 0);
    phase(80, 100, 3, 3, 100, 10, 32'h100, 1, 0, 0);
    phase(30, 100, 1, 2, 100, 0, 32'hFFFF_FFF8, 0, 1, 0);
    phase(400, 70, 1, 4, 60, 8, 32'h0000_4000, 1, 0, 0);
    phase(300, 80, 1, 3, 70, 5, 32'hFFFF_FF00, 1, 0, 15);
    phase(20, 100, 1, 1, 100, 0, 32'h0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
